// File: rtl/ssp_uart_ctrl_pkg.sv
// Shared types and constants for the SSP_UART master sequencer.
package ssp_uart_ctrl_pkg;

    // Frame sequencer states, in the order a frame walks through them
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4,
        GAP   = 3'd5
    } state_t;

    // Frame layout: 3-bit RA + WnR header, then the data bits
    localparam int ADDR_BITS  = 4;
    localparam int DATA_BITS  = 12;
    localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;

    // SSP_UART register map as seen on SSP_RA
    localparam logic [2:0] REG_THR = 3'd0;   // transmit holding
    localparam logic [2:0] REG_RHR = 3'd1;   // receive holding
    localparam logic [2:0] REG_USR = 3'd2;   // status
    localparam logic [2:0] REG_UCR = 3'd3;   // control
    localparam logic [2:0] REG_SPR = 3'd4;   // scratch
    localparam logic [2:0] REG_BRR = 3'd5;   // baud rate
    localparam logic [2:0] REG_IER = 3'd6;   // interrupt enable
    localparam logic [2:0] REG_ISR = 3'd7;   // interrupt status

    // Round-robin pick: a lone requester wins; on contention the port not
    // served last wins. Returns the winning port index.
    function automatic logic rr_pick(input logic req0, input logic req1,
                                     input logic last_served);
        if (req0 && req1)
            return ~last_served;
        return req1;
    endfunction

endpackage

// File: rtl/ssp_uart_ctrl_sck_gen.sv
// SSP serial clock generator: half-period divider plus frame bit counter.
// A Start pulse arms one frame of FRAME_BITS bit periods; each period is
// SCK low for pSCK_DIV clocks then SCK high for pSCK_DIV clocks.
module ssp_sck_gen
    import ssp_uart_ctrl_pkg::*;
#(
    parameter int pSCK_DIV = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    output logic       SCK,
    output logic [4:0] BitIdx,
    output logic       LastBit,
    output logic       PeriodEnd,
    output logic       FrameEnd
);

    localparam logic [7:0] DIV_LAST = 8'(pSCK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

    logic       running;
    logic       half;       // 0 = low half of the bit period, 1 = high half
    logic [7:0] div_cnt;
    logic [4:0] bit_cnt;
    logic       half_end;

    assign half_end  = running && (div_cnt == DIV_LAST);
    assign PeriodEnd = half_end && half;
    assign FrameEnd  = PeriodEnd && (bit_cnt == BIT_LAST);
    assign SCK       = running && half;
    assign BitIdx    = bit_cnt;
    assign LastBit   = running && (bit_cnt == BIT_LAST);

    // Divider, half-period phase and bit counter; stops itself after the last bit
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            running <= 1'b0;
            half    <= 1'b0;
            div_cnt <= 8'd0;
            bit_cnt <= 5'd0;
        end else if (Start) begin
            running <= 1'b1;
            half    <= 1'b0;
            div_cnt <= 8'd0;
            bit_cnt <= 5'd0;
        end else if (running) begin
            if (half_end) begin
                div_cnt <= 8'd0;
                half    <= ~half;
                if (half) begin
                    if (bit_cnt == BIT_LAST) begin
                        running <= 1'b0;
                        bit_cnt <= 5'd0;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ssp_uart_ctrl.sv
// SSP master sequencer with a two-port round-robin arbiter in front of the
// SSP_UART register interface. Each grant produces one 16-bit frame
// (RA, WnR, 12 data bits) and returns SSP_DO to the winner with an Ack.
module ssp_uart_ctrl
    import ssp_uart_ctrl_pkg::*;
#(
    parameter int pSCK_DIV = 2,
    parameter int pGAP     = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Req0,
    input  logic [2:0]           RA0,
    input  logic                 WnR0,
    input  logic [DATA_BITS-1:0] DI0,
    input  logic                 Req1,
    input  logic [2:0]           RA1,
    input  logic                 WnR1,
    input  logic [DATA_BITS-1:0] DI1,
    output logic                 Gnt0,
    output logic                 Gnt1,
    output logic                 Ack0,
    output logic                 Ack1,
    output logic [DATA_BITS-1:0] RdData,
    output logic                 Busy,
    output logic                 SSP_SSEL,
    output logic                 SSP_SCK,
    output logic [2:0]           SSP_RA,
    output logic                 SSP_WnR,
    output logic                 SSP_En,
    output logic                 SSP_EOC,
    output logic [DATA_BITS-1:0] SSP_DI,
    input  logic [DATA_BITS-1:0] SSP_DO
);

    localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
    localparam logic [3:0] GAP_LAST  = (pGAP > 0) ? 4'(pGAP - 1) : 4'd0;

    state_t               state;
    state_t               state_nxt;
    logic                 win;          // port owning the current frame
    logic                 last_served;  // round-robin pointer
    logic                 pick;
    logic                 any_req;
    logic [3:0]           gap_cnt;
    logic [2:0]           ra_q;
    logic                 wnr_q;
    logic [DATA_BITS-1:0] di_q;
    logic [DATA_BITS-1:0] rd_q;

    logic                 sck_start;
    logic                 sck;
    logic [4:0]           bit_idx;
    logic                 last_bit;
    logic                 period_end;
    logic                 frame_end;

    assign any_req   = Req0 | Req1;
    assign pick      = rr_pick(Req0, Req1, last_served);
    assign sck_start = (state == SETUP);

    assign SSP_RA  = ra_q;
    assign SSP_WnR = wnr_q;
    assign SSP_DI  = di_q;
    assign RdData  = rd_q;

    ssp_sck_gen #(
        .pSCK_DIV (pSCK_DIV)
    ) u_sck_gen (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (sck_start),
        .SCK       (sck),
        .BitIdx    (bit_idx),
        .LastBit   (last_bit),
        .PeriodEnd (period_end),
        .FrameEnd  (frame_end)
    );

    // State register; reset aborts any frame in flight
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Frame sequencing: header bits end on the 4th period end, frame on the 16th
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = SETUP;
            SETUP:   state_nxt = ADDR;
            ADDR:    if (period_end && (bit_idx == ADDR_LAST)) state_nxt = DATA;
            DATA:    if (frame_end) state_nxt = DONE;
            DONE:    state_nxt = (pGAP == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state strobes and SSP control lines
    always_comb begin
        Gnt0     = 1'b0;
        Gnt1     = 1'b0;
        Ack0     = 1'b0;
        Ack1     = 1'b0;
        Busy     = 1'b1;
        SSP_SSEL = 1'b0;
        SSP_SCK  = 1'b0;
        SSP_En   = 1'b0;
        SSP_EOC  = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
            end
            SETUP: begin
                Gnt0     = ~win;
                Gnt1     = win;
                SSP_SSEL = 1'b1;
            end
            ADDR: begin
                SSP_SSEL = 1'b1;
                SSP_SCK  = sck;
            end
            DATA: begin
                SSP_SSEL = 1'b1;
                SSP_SCK  = sck;
                SSP_En   = 1'b1;
                SSP_EOC  = last_bit;
            end
            DONE: begin
                Ack0 = ~win;
                Ack1 = win;
            end
            GAP: begin
                Busy = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    // Arbitration: the winner's fields are latched as IDLE hands over to
    // SETUP, so SSP_RA/WnR/DI hold from SETUP until the next SETUP
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            win         <= 1'b0;
            last_served <= 1'b1;
            ra_q        <= 3'd0;
            wnr_q       <= 1'b0;
            di_q        <= '0;
        end else if ((state == IDLE) && any_req) begin
            win   <= pick;
            ra_q  <= pick ? RA1  : RA0;
            wnr_q <= pick ? WnR1 : WnR0;
            di_q  <= pick ? DI1  : DI0;
        end else if (state == SETUP) begin
            last_served <= win;
        end
    end

    // Read-back capture on the last clock of the frame so RdData is valid with Ack
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            rd_q <= '0;
        else if ((state == DATA) && frame_end)
            rd_q <= SSP_DO;
    end

    // Inter-frame gap counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            gap_cnt <= 4'd0;
        else if (state == DONE)
            gap_cnt <= 4'd0;
        else if (state == GAP)
            gap_cnt <= gap_cnt + 4'd1;
    end

endmodule

// File: tb/tb_ssp_uart_ctrl.sv
// Self-checking bench for ssp_uart_ctrl: a scoreboard of issued requests per
// port, a monitor that checks grants, frame shape and Ack/RdData, plus a
// second instance with pSCK_DIV=1, pGAP=0 for the timing sweep.
module tb_ssp_uart_ctrl;

    localparam int A_DIV = 2;
    localparam int A_GAP = 2;
    localparam int T_A   = 2 * A_DIV;
    localparam int B_DIV = 1;
    localparam int B_GAP = 0;
    localparam int T_B   = 2 * B_DIV;

    // Frame arithmetic straight from the frame rules
    localparam int A_GNT2ACK  = 1 + 16 * T_A;           // SETUP + 16 bit periods
    localparam int A_GNT2GNT  = 1 + 16 * T_A + 1 + A_GAP + 1;
    localparam int B_ACK_CYC  = 1 + 1 + 16 * T_B;
    localparam int B_GNT2_CYC = B_ACK_CYC + B_GAP + 2;

    typedef struct packed {
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] di;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_b = 1'b0;

    logic        req0 = 0, req1 = 0, wnr0 = 0, wnr1 = 0;
    logic [2:0]  ra0 = 0, ra1 = 0;
    logic [11:0] di0 = 0, di1 = 0;
    logic        gnt0, gnt1, ack0, ack1, busy, ssel, sck, ssp_wnr, en, eoc;
    logic [11:0] rd_data, ssp_di, ssp_do;
    logic [2:0]  ssp_ra;

    logic        b_req0 = 0, b_wnr0 = 0;
    logic [2:0]  b_ra0 = 0;
    logic [11:0] b_di0 = 0;
    logic        b_req1 = 0, b_wnr1 = 0;
    logic [2:0]  b_ra1 = 0;
    logic [11:0] b_di1 = 0;
    logic [11:0] b_ssp_do = 12'h5A5;
    logic        b_gnt0, b_gnt1, b_ack0, b_ack1, b_busy, b_ssel, b_sck, b_wnr, b_en, b_eoc;
    logic [11:0] b_rd_data, b_di;
    logic [2:0]  b_ra;

    logic [11:0] rom [8];   // behavioural SSP_UART: fixed read-back per address
    assign ssp_do = rom[ssp_ra];

    int n_checks = 0;
    int n_errors = 0;

    req_t q0[$];
    req_t q1[$];
    int   gnt_cyc_log[$];
    int   gnt_port_log[$];
    int   idle_log[$];

    always #5 clk = ~clk;

    ssp_uart_ctrl #(.pSCK_DIV(A_DIV), .pGAP(A_GAP)) dut (
        .Clk(clk), .Rst(rst_n),
        .Req0(req0), .RA0(ra0), .WnR0(wnr0), .DI0(di0),
        .Req1(req1), .RA1(ra1), .WnR1(wnr1), .DI1(di1),
        .Gnt0(gnt0), .Gnt1(gnt1), .Ack0(ack0), .Ack1(ack1),
        .RdData(rd_data), .Busy(busy),
        .SSP_SSEL(ssel), .SSP_SCK(sck), .SSP_RA(ssp_ra), .SSP_WnR(ssp_wnr),
        .SSP_En(en), .SSP_EOC(eoc), .SSP_DI(ssp_di), .SSP_DO(ssp_do)
    );

    ssp_uart_ctrl #(.pSCK_DIV(B_DIV), .pGAP(B_GAP)) dut_b (
        .Clk(clk), .Rst(rst_b),
        .Req0(b_req0), .RA0(b_ra0), .WnR0(b_wnr0), .DI0(b_di0),
        .Req1(b_req1), .RA1(b_ra1), .WnR1(b_wnr1), .DI1(b_di1),
        .Gnt0(b_gnt0), .Gnt1(b_gnt1), .Ack0(b_ack0), .Ack1(b_ack1),
        .RdData(b_rd_data), .Busy(b_busy),
        .SSP_SSEL(b_ssel), .SSP_SCK(b_sck), .SSP_RA(b_ra), .SSP_WnR(b_wnr),
        .SSP_En(b_en), .SSP_EOC(b_eoc), .SSP_DI(b_di), .SSP_DO(b_ssp_do)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Raise a request, log its expected frame, hold it until granted
    task automatic issue(input int p, input logic [2:0] ra, input logic wnr,
                         input logic [11:0] di);
        req_t r;
        int   n;
        r.ra = ra; r.wnr = wnr; r.di = di;
        @(posedge clk); #2;
        if (p == 0) begin
            ra0 = ra; wnr0 = wnr; di0 = di; req0 = 1'b1; q0.push_back(r);
        end else begin
            ra1 = ra; wnr1 = wnr; di1 = di; req1 = 1'b1; q1.push_back(r);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((p == 0) ? gnt0 : gnt1) && n < 400);
        check("grant_wait", (n < 400), 1);
        @(posedge clk); #2;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic port_traffic(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 90)) @(posedge clk);
            issue(p, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 12'($urandom));
        end
    endtask

    // Monitor state
    int   mon_cyc, g_cyc, rises, en_n, eoc_n, ssel_n, idle_run;
    logic prev_busy, prev_r0, prev_r1, prev_sck, last_m, active, cur_port, fld_bad;
    logic [1:0] exp_g;
    req_t cur;

    // Monitor: arbitration model on each Gnt, frame shape and read-back on each Ack
    initial begin
        mon_cyc = 0; idle_run = 0; prev_busy = 0; prev_r0 = 0; prev_r1 = 0;
        prev_sck = 0; last_m = 1; active = 0; cur_port = 0; fld_bad = 0;
        g_cyc = 0; rises = 0; en_n = 0; eoc_n = 0; ssel_n = 0; cur = '0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (!rst_n) begin
                if (active) begin
                    if (cur_port) void'(q1.pop_front());
                    else          void'(q0.pop_front());
                end
                active = 0;
                last_m = 1;
            end else begin
                if (gnt0 || gnt1) begin
                    if (prev_busy || !(prev_r0 || prev_r1)) exp_g = 2'b00;
                    else if (prev_r0 && prev_r1)            exp_g = last_m ? 2'b01 : 2'b10;
                    else                                    exp_g = prev_r1 ? 2'b10 : 2'b01;
                    check("grant_port", {gnt1, gnt0}, exp_g);
                    cur_port = gnt1;
                    last_m   = gnt1;
                    if (cur_port) begin
                        check("grant_pending", (q1.size() > 0), 1);
                        if (q1.size() > 0) cur = q1[0];
                    end else begin
                        check("grant_pending", (q0.size() > 0), 1);
                        if (q0.size() > 0) cur = q0[0];
                    end
                    gnt_cyc_log.push_back(mon_cyc);
                    gnt_port_log.push_back(int'(cur_port));
                    idle_log.push_back(idle_run);
                    active = 1; g_cyc = mon_cyc; fld_bad = 0;
                    rises = 0; en_n = 0; eoc_n = 0; ssel_n = 0;
                end
                if (active) begin
                    if (sck && !prev_sck) rises++;
                    en_n   += int'(en);
                    eoc_n  += int'(eoc);
                    ssel_n += int'(ssel);
                    if (ssel && ({ssp_ra, ssp_wnr, ssp_di} !== {cur.ra, cur.wnr, cur.di}))
                        fld_bad = 1;
                end
                if (ack0 || ack1) begin
                    check("ack_in_frame", active, 1);
                    if (active) begin
                        check("ack_port", {ack1, ack0}, cur_port ? 2'b10 : 2'b01);
                        check("ack_latency", mon_cyc - g_cyc, A_GNT2ACK);
                        check("sck_rises", rises, 16);
                        check("en_cycles", en_n, 12 * T_A);
                        check("eoc_cycles", eoc_n, T_A);
                        check("ssel_cycles", ssel_n, A_GNT2ACK);
                        check("fields_stable", fld_bad, 0);
                        check("rd_data", rd_data, rom[cur.ra]);
                        check("done_lines_low", {ssel, sck, en, eoc}, 0);
                        if (cur_port) void'(q1.pop_front());
                        else          void'(q0.pop_front());
                        active = 0;
                    end
                end
            end
            idle_run  = busy ? 0 : idle_run + 1;
            prev_busy = busy;
            prev_r0   = req0;
            prev_r1   = req1;
            prev_sck  = sck;
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    int base, cnt, bg1, bg2, ba1, b_hi, b_rises, b_en_n;
    logic [11:0] b_rd;
    logic b_prev_sck;

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 12'($urandom);
        rom[2] = 12'hA5C;

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs_a", {gnt0, gnt1, ack0, ack1, rd_data, busy, ssel, sck,
                                  ssp_ra, ssp_wnr, en, eoc, ssp_di}, 0);
        check("reset_outputs_b", {b_gnt0, b_gnt1, b_ack0, b_ack1, b_rd_data, b_busy,
                                  b_ssel, b_sck, b_ra, b_wnr, b_en, b_eoc, b_di}, 0);
        rst_n = 1'b1;
        rst_b = 1'b1;

        // Timing sweep at pSCK_DIV=1, pGAP=0 with port 0 requesting continuously
        @(posedge clk); #2;
        b_ra0 = 3'd5; b_wnr0 = 1'b0; b_di0 = 12'h123; b_req0 = 1'b1;
        bg1 = -1; bg2 = -1; ba1 = -1; b_hi = 0; b_rises = 0; b_en_n = 0;
        b_prev_sck = 0; b_rd = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (b_gnt0) begin
                if (bg1 < 0) bg1 = k;
                else if (bg2 < 0) bg2 = k;
            end
            if (b_ack0 && ba1 < 0) begin
                ba1 = k;
                b_rd = b_rd_data;
            end
            if (k >= 2 && k <= 1 + 16 * T_B) begin
                b_hi   += int'(b_sck);
                b_en_n += int'(b_en);
                if (b_sck && !b_prev_sck) b_rises++;
            end
            b_prev_sck = b_sck;
            if (bg2 >= 0) b_req0 = 1'b0;
        end
        check("sweep_gnt_cycle", bg1, 1);
        check("sweep_ack_cycle", ba1, B_ACK_CYC);
        check("sweep_next_gnt", bg2, B_GNT2_CYC);
        check("sweep_sck_high", b_hi, 8 * T_B);
        check("sweep_sck_rises", b_rises, 16);
        check("sweep_en_cycles", b_en_n, 12 * T_B);
        check("sweep_rd_data", b_rd, 12'h5A5);

        // Contention: both ports back-to-back for four frames
        base = gnt_cyc_log.size();
        fork
            begin
                issue(0, 3'd3, 1'b1, 12'h111);
                issue(0, 3'd4, 1'b0, 12'h222);
            end
            begin
                issue(1, 3'd6, 1'b0, 12'h333);
                issue(1, 3'd7, 1'b1, 12'h444);
            end
        join
        repeat (A_GNT2GNT + 10) @(posedge clk);
        check("contention_frames", gnt_cyc_log.size() - base, 4);
        if (gnt_cyc_log.size() - base >= 4) begin
            for (int i = 0; i < 4; i++)
                check("contention_order", gnt_port_log[base + i], i % 2);
            for (int i = 1; i < 4; i++) begin
                check("contention_spacing", gnt_cyc_log[base + i] - gnt_cyc_log[base + i - 1],
                      A_GNT2GNT);
                check("contention_idle_gap", idle_log[base + i], 1);
            end
        end

        // Single read and single write
        issue(0, 3'b010, 1'b0, 12'h0F0);
        repeat (A_GNT2GNT) @(posedge clk);
        issue(1, 3'b001, 1'b1, 12'h3F0);
        repeat (A_GNT2GNT) @(posedge clk);

        // Withdrawn request: one-cycle Req0 pulse while busy is never served
        issue(1, 3'd5, 1'b0, 12'h00A);
        @(posedge clk); #2;
        ra0 = 3'd2; wnr0 = 1'b1; di0 = 12'hBAD; req0 = 1'b1;
        @(posedge clk); #2;
        req0 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            cnt += int'(gnt0);
        end
        check("withdrawn_no_gnt0", cnt, 0);

        // Reset during data bit 8, then port 1 is granted right after release
        issue(0, 3'd1, 1'b1, 12'h5C3);
        repeat (16 + 8 * T_A + 1) @(posedge clk);
        #2;
        check("pre_reset_in_data", en, 1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {gnt0, gnt1, ack0, ack1, rd_data, busy, ssel, sck,
                                ssp_ra, ssp_wnr, en, eoc, ssp_di}, 0);
        @(posedge clk); #2;
        ra1 = 3'd6; wnr1 = 1'b0; di1 = 12'h0C0; req1 = 1'b1;
        q1.push_back('{ra: 3'd6, wnr: 1'b0, di: 12'h0C0});
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("gnt1_after_reset", {gnt1, gnt0}, 2'b10);
        #1;
        req1 = 1'b0;
        repeat (A_GNT2GNT + 5) @(posedge clk);

        // Randomised traffic on both ports
        fork
            port_traffic(0, 6);
            port_traffic(1, 6);
        join
        repeat (A_GNT2GNT + 20) @(posedge clk);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("no_open_frame", active, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ssp_uart_ctrl.md
Name: ssp_uart_ctrl

Overview:
SSP master sequencer and two-port arbiter in front of the SSP_UART register interface. It accepts register read/write requests from two on-chip requesters (port 0: host command path; port 1: interrupt service engine) and grants them round-robin. For each granted request it drives one 16-bit SSP frame: 3-bit RA, 1-bit WnR, then 12 data bits. It returns SSP_DO to the granted requester with a one-cycle Ack.

Parameters:
pSCK_DIV, 2, Clk cycles per SSP_SCK half-period (legal 1..255)
pGAP, 2, idle Clk cycles forced between frames (legal 0..15)

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous reset, active-low
Req0  in  1  port 0 request, held until Gnt0
RA0  in  3  port 0 register address
WnR0  in  1  port 0 command: 1 = write, 0 = read
DI0  in  12  port 0 write data
Req1, RA1, WnR1, DI1  in  1/3/1/12  port 1, same meaning as port 0
Gnt0, Gnt1  out  1  one-cycle pulse; request fields latched this cycle
Ack0, Ack1  out  1  one-cycle pulse; frame complete, RdData valid
RdData  out  12  SSP_DO captured at end of the last frame, held until the next capture
Busy  out  1  high from SETUP through GAP
SSP_SSEL  out  1  slave select, active-high during a frame
SSP_SCK  out  1  serial clock, idle low
SSP_RA  out  3  latched address
SSP_WnR  out  1  latched command
SSP_En  out  1  high during the 12 data-bit periods
SSP_EOC  out  1  high during the final bit period
SSP_DI  out  12  latched write data
SSP_DO  in  12  data returned by SSP_UART

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; every output 0; round-robin pointer favours port 0. Rst asserted mid-frame aborts the frame immediately: no Ack, SSEL/SCK drop to 0.
- Bit period T = 2*pSCK_DIV Clk cycles. SCK is low for the first half of each period and high for the second half. Each frame produces exactly 16 SCK rising edges.
- States: IDLE -> SETUP -> ADDR -> DATA -> DONE -> GAP -> IDLE. GAP is skipped when pGAP=0.
- IDLE: Busy=0. If any Req is high, pick the winner: if only one port requests, it wins; if both request, the port not served last wins. Next cycle is SETUP.
- SETUP (1 Clk): Gnt pulse to the winner. RA/WnR/DI latched onto SSP_RA/SSP_WnR/SSP_DI. SSEL=1, SCK=0. Pointer updated.
- ADDR (4*T Clk): SSEL=1, En=0, EOC=0, SCK toggling.
- DATA (12*T Clk): En=1. EOC=1 only for the 12th bit period.
- DONE (1 Clk): SSEL=En=EOC=SCK=0. RdData <= SSP_DO. Ack pulse to the winner. RdData is captured on writes as well as reads.
- GAP (pGAP Clk): Busy=1, requests not sampled.
- Latency at pSCK_DIV=2, pGAP=2: Req seen in IDLE at cycle 0 -> Gnt at cycle 1 -> Ack at cycle 66 -> IDLE at cycle 69. The earliest next Gnt is at cycle 70.
- SSP_RA/WnR/DI remain stable from SETUP until the next SETUP.
- A Req dropped before its Gnt is not served. Req changes after Gnt are ignored until IDLE.
- Requesters are never starved: with both requesting continuously, grants strictly alternate.
- Counters: bit counter is 5 bits (0..15); divider is 8 bits and wraps at pSCK_DIV-1; gap counter is 4 bits.

Decomposition:
- Package ssp_uart_ctrl_pkg holds:
  - the state enum {IDLE, SETUP, ADDR, DATA, DONE, GAP};
  - constants ADDR_BITS=4, DATA_BITS=12, FRAME_BITS=16;
  - the SSP_UART register address localparams.
- Sub-module ssp_sck_gen: divider plus bit counter. Inputs: Start, Clk, Rst. Outputs: SCK, BitIdx[4:0], LastBit, FrameEnd pulse.

Test Plan:
- Single read: Req0=1, RA0=3'b010, WnR0=0, SSP_DO model=12'hA5C. Required response: Gnt0 at cycle 1, 16 SCK rises, En high for 48 Clk, EOC high for 4 Clk, Ack0 at cycle 66, RdData=12'hA5C.
- Single write: Req1=1, RA1=3'b001, WnR1=1, DI1=12'h3F0. Required response: SSP_RA=1, SSP_WnR=1, SSP_DI=12'h3F0 stable through the frame; Ack1 only; Gnt0/Ack0 stay 0.
- Contention: Req0 and Req1 held high for 4 frames. Required response: grant order 0,1,0,1; Gnt spacing 69 Clk; Busy low for exactly 1 cycle between frames.
- Reset mid-DATA: drive Rst=0 at bit 8 of the data phase. Required response: all outputs 0 within the same cycle, no Ack. After Rst=1 with Req1 held, Gnt1 arrives 1 cycle later (the pointer is not an issue since only port 1 requests).
- Parameter sweep: pSCK_DIV=1 and pGAP=0. Required response: T=2, Ack at cycle 34, next Gnt at cycle 36; SCK duty exactly 50%.
- Withdrawn request: Req0 pulsed for 1 cycle while Busy=1. Required response: no Gnt0 and no frame.
